// File: rtl/usb_tx_ctrl.sv
// USB full-speed transmit controller: sends SYNC, upstream bytes and EOP,
// LSB first and NRZI-encoded onto registered d_plus/d_minus pad drives.
module usb_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic       data_valid,
  input  logic [7:0] tx_data,
  output logic       get_byte,
  output logic       d_plus,
  output logic       d_minus,
  output logic       transmitting,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             nrzi_level;

  logic bit_end;
  logic byte_end;
  logic se0_end;
  logic start_pkt;
  logic tx_bit_valid;
  logic tx_bit;
  logic level_base;
  logic level_next;

  assign start_pkt = (state == IDLE) && tx_start;
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign byte_end  = bit_end && (bit_idx == 3'd7) && ((state == SYNC) || (state == DATA));
  assign se0_end   = bit_end && (bit_idx == 3'd1) && (state == EOP_SE0);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (tx_start) next_state = SYNC;
      end
      SYNC, DATA: begin
        if (byte_end) next_state = data_valid ? DATA : EOP_SE0;
      end
      EOP_SE0: begin
        if (se0_end) next_state = EOP_J;
      end
      EOP_J: begin
        if (bit_end) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    transmitting = (state != IDLE);
    get_byte     = byte_end && data_valid;
  end

  // Pick the bit that starts on the coming edge; its NRZI level is
  // computed from J at packet start, otherwise from the current level.
  always_comb begin
    tx_bit_valid = 1'b0;
    tx_bit       = 1'b0;
    if (start_pkt) begin
      tx_bit_valid = 1'b1;
      tx_bit       = SYNC_PATTERN[0];
    end else if (((state == SYNC) || (state == DATA)) && bit_end) begin
      if (!byte_end) begin
        tx_bit_valid = 1'b1;
        tx_bit       = shift_reg[1];
      end else if (data_valid) begin
        tx_bit_valid = 1'b1;
        tx_bit       = tx_data[0];
      end
    end
    level_base = start_pkt ? 1'b1 : nrzi_level;
    level_next = tx_bit ? level_base : ~level_base;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
        bit_idx <= 3'd0;
      end else if (bit_end) begin
        bit_cnt <= '0;
        bit_idx <= (next_state != state) ? 3'd0 : bit_idx + 3'd1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (start_pkt) begin
        shift_reg <= SYNC_PATTERN;
      end else if (byte_end && data_valid) begin
        shift_reg <= tx_data;
      end else if (((state == SYNC) || (state == DATA)) && bit_end) begin
        shift_reg <= {1'b0, shift_reg[7:1]};
      end
    end
  end

  // Line drive: data bits carry the NRZI level, otherwise the line
  // follows the state being entered (SE0 for EOP, J for EOP_J/IDLE).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_plus     <= 1'b1;
      d_minus    <= 1'b0;
      nrzi_level <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= (state == EOP_J) && bit_end;
      if (tx_bit_valid) begin
        nrzi_level <= level_next;
        d_plus     <= level_next;
        d_minus    <= ~level_next;
      end else begin
        case (next_state)
          EOP_SE0: begin
            d_plus  <= 1'b0;
            d_minus <= 1'b0;
          end
          IDLE, EOP_J: begin
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
          end
          default: begin
            d_plus  <= d_plus;
            d_minus <= d_minus;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Scoreboard bench for usb_tx_ctrl: per-cycle expected line/status values are
// queued when a packet is launched and compared on each falling clock edge.
module tb_usb_tx_ctrl;

  localparam int CPB = 8;
  localparam logic [4:0] IDLE_V = 5'b10000;

  logic       clk;
  logic       n_rst;
  logic       tx_start;
  logic       data_valid;
  logic [7:0] tx_data;
  logic       get_byte;
  logic       d_plus;
  logic       d_minus;
  logic       transmitting;
  logic       tx_done;

  // Expected vector layout: {d_plus, d_minus, transmitting, get_byte, tx_done}
  typedef struct {
    int         scen;
    int         cyc;
    logic [4:0] val;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       build_q[$];
  exp_t       mon_e;
  int         build_cyc;
  logic [7:0] src_q[$];
  int         n_compared = 0;
  int         n_mismatched = 0;

  usb_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_start     (tx_start),
    .data_valid   (data_valid),
    .tx_data      (tx_data),
    .get_byte     (get_byte),
    .d_plus       (d_plus),
    .d_minus      (d_minus),
    .transmitting (transmitting),
    .tx_done      (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput($sformatf("s%0d_c%0d", mon_e.scen, mon_e.cyc),
                  32'({d_plus, d_minus, transmitting, get_byte, tx_done}),
                  32'(mon_e.val));
    end
  end

  task automatic push_exp(input int scen, input logic [4:0] val);
    exp_t e;
    e.scen = scen;
    e.cyc  = build_cyc;
    e.val  = val;
    build_q.push_back(e);
    build_cyc++;
  endtask

  // Reference packet: SYNC then bytes LSB first, NRZI from J, 2 bits SE0, 1 bit J, tx_done
  task automatic add_packet(input int scen, input logic [7:0] bytes[$]);
    logic       level;
    logic [7:0] cur;
    logic       gb;
    level = 1'b1;
    for (int k = 0; k <= bytes.size(); k++) begin
      cur = (k == 0) ? 8'h80 : bytes[k-1];
      for (int b = 0; b < 8; b++) begin
        if (!cur[b]) level = ~level;
        for (int c = 0; c < CPB; c++) begin
          gb = (b == 7) && (c == CPB - 1) && (k < bytes.size());
          push_exp(scen, {level, ~level, 1'b1, gb, 1'b0});
        end
      end
    end
    repeat (2 * CPB) push_exp(scen, 5'b00100);
    repeat (CPB) push_exp(scen, 5'b10100);
    push_exp(scen, 5'b10001);
  endtask

  task automatic drive_source();
    data_valid = (src_q.size() > 0);
    tx_data    = (src_q.size() > 0) ? src_q[0] : 8'h00;
  endtask

  task automatic applyStimulus(input int scen, input logic [7:0] bytes[$],
                               input bit hold_start, input int reset_cycle);
    int   cyc;
    int   total;
    int   release_cyc;
    logic gb;
    build_q.delete();
    build_cyc = 0;
    push_exp(scen, IDLE_V);
    add_packet(scen, bytes);
    if (hold_start) add_packet(scen, bytes);
    if (reset_cycle >= 0) begin
      while (build_q.size() > reset_cycle) void'(build_q.pop_back());
      build_cyc = reset_cycle;
    end
    repeat (12) push_exp(scen, IDLE_V);
    total       = build_q.size();
    release_cyc = hold_start ? 100 : 1;

    @(posedge clk);
    #1;
    src_q = bytes;
    foreach (build_q[i]) exp_q.push_back(build_q[i]);
    tx_start = 1'b1;
    drive_source();
    cyc = 0;
    while (cyc < total - 1) begin
      @(negedge clk);
      gb = get_byte;
      @(posedge clk);
      #1;
      cyc++;
      if (gb && (src_q.size() > 0)) void'(src_q.pop_front());
      drive_source();
      if (cyc == release_cyc) tx_start = 1'b0;
      if (cyc == reset_cycle) n_rst = 1'b0;
      if ((reset_cycle >= 0) && (cyc == reset_cycle + 3)) n_rst = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    checkOutput($sformatf("s%0d_drain", scen), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] none[$];
    logic [7:0] one[$];
    logic [7:0] three[$];

    n_rst      = 1'b0;
    tx_start   = 1'b0;
    data_valid = 1'b0;
    tx_data    = 8'h00;
    one.push_back(8'hA5);
    three.push_back(8'h00);
    three.push_back(8'hFF);
    three.push_back(8'h3C);

    repeat (2) @(negedge clk);
    checkOutput("rst_d_plus", 32'(d_plus), 32'd1);
    checkOutput("rst_d_minus", 32'(d_minus), 32'd0);
    checkOutput("rst_transmitting", 32'(transmitting), 32'd0);
    checkOutput("rst_get_byte", 32'(get_byte), 32'd0);
    checkOutput("rst_tx_done", 32'(tx_done), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("idle_hold", 32'({d_plus, d_minus, transmitting, get_byte, tx_done}), 32'(IDLE_V));
    end

    $display("[TB] empty packet");
    applyStimulus(2, none, 1'b0, -1);
    $display("[TB] single byte A5");
    applyStimulus(3, one, 1'b0, -1);
    $display("[TB] three bytes 00 FF 3C");
    applyStimulus(4, three, 1'b0, -1);
    $display("[TB] reset mid-packet");
    applyStimulus(5, one, 1'b0, 100);
    $display("[TB] empty packet after reset");
    applyStimulus(52, none, 1'b0, -1);
    $display("[TB] tx_start held high");
    applyStimulus(6, none, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
